// File: rtl/boot_run_ctrl_pkg.sv
// Shared types and helpers for the boot-and-run sequencer.
// Holds the controller state encoding, instruction size and index-width helper.
package boot_pkg;

  typedef enum logic [2:0] {
    LOAD,
    HOLD,
    RUN,
    DONE,
    ERROR
  } state_e;

  localparam int INST_BYTES = 4;

  function automatic int addr_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/boot_run_ctrl_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-value compare.
// Used by boot_run_ctrl for both the core reset hold window and the run budget.
module boot_run_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);

  logic [WIDTH-1:0] count_d, count_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_term = (count_q == term_val);

endmodule

// File: rtl/boot_run_ctrl.sv
// Boot-and-run sequencer: streams an image into IMem, holds core reset, then bounds the run.
// Optional BOOT_CHECKSUM_EN adds a running-XOR image checksum checked on the last word.
module boot_run_ctrl
  import boot_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RST_HOLD   = 4,
  parameter int                    RUN_CYCLES = 1000,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  in_Clk,
  input  logic                  Rst_N,
  input  logic                  in_load_valid,
  input  logic [INST_WIDTH-1:0] in_load_data,
  input  logic                  in_load_last,
  output logic                  out_load_ready,
  output logic                  out_imem_wr_en,
  output logic [DATA_WIDTH-1:0] out_imem_wr_addr,
  output logic [INST_WIDTH-1:0] out_imem_wr_data,
  output logic                  out_done_load_inst,
  output logic                  out_core_rst_n,
  input  logic                  in_halt,
  output logic                  out_run_done,
  output logic                  out_timeout,
  output logic                  out_error,
`ifdef BOOT_CHECKSUM_EN
  input  logic [INST_WIDTH-1:0] in_load_csum,
  output logic                  out_csum_ok,
`endif
  output logic [CNT_WIDTH-1:0]  out_cycle_count
);

  localparam int                    IDX_W     = addr_idx_width(DEPTH);
  localparam int                    HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0]     HOLD_TERM = HOLD_W'(RST_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0]  RUN_TERM  = CNT_WIDTH'(RUN_CYCLES - 1);

  state_e                state_d, state_q;
  logic [IDX_W-1:0]      idx_d, idx_q;
  logic                  load_ready_d, load_ready_q;
  logic                  wr_en_d, wr_en_q;
  logic [DATA_WIDTH-1:0] wr_addr_d, wr_addr_q;
  logic [INST_WIDTH-1:0] wr_data_d, wr_data_q;
  logic                  timeout_d, timeout_q;
`ifdef BOOT_CHECKSUM_EN
  logic [INST_WIDTH-1:0] csum_d, csum_q;
  logic                  csum_ok_d, csum_ok_q;
`endif

  logic                  xfer;
  logic                  hold_done;
  logic                  budget_hit;
  logic                  run_clr, run_en;
  logic [HOLD_W-1:0]     hold_count_unused;
  logic [CNT_WIDTH-1:0]  run_count;

  assign xfer = (state_q == LOAD) && load_ready_q && in_load_valid;

  boot_run_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk      (in_Clk),
    .rst_n    (Rst_N),
    .clr      (state_q != HOLD),
    .en       (state_q == HOLD),
    .term_val (HOLD_TERM),
    .count    (hold_count_unused),
    .at_term  (hold_done)
  );

  // The run count stops on the exiting cycle so DONE shows the last RUN value.
  assign run_clr = (state_q != RUN) && (state_q != DONE);
  assign run_en  = (state_q == RUN) && !in_halt && !budget_hit;

  boot_run_counter #(.WIDTH(CNT_WIDTH)) u_run_cnt (
    .clk      (in_Clk),
    .rst_n    (Rst_N),
    .clr      (run_clr),
    .en       (run_en),
    .term_val (RUN_TERM),
    .count    (run_count),
    .at_term  (budget_hit)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    timeout_d = timeout_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d    = csum_q;
    csum_ok_d = csum_ok_q;
`endif
    case (state_q)
      LOAD: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + DATA_WIDTH'(idx_q) * DATA_WIDTH'(INST_BYTES);
          wr_data_d = in_load_data;
          idx_d     = idx_q + IDX_W'(1);
`ifdef BOOT_CHECKSUM_EN
          csum_d    = csum_q ^ in_load_data;
`endif
          if (in_load_last) begin
`ifdef BOOT_CHECKSUM_EN
            csum_ok_d = (csum_d == in_load_csum);
            state_d   = csum_ok_d ? HOLD : ERROR;
`else
            state_d   = HOLD;
`endif
          end else if (idx_q == LAST_IDX) begin
            state_d = ERROR;
          end
        end
      end
      HOLD: begin
        if (hold_done) state_d = RUN;
      end
      RUN: begin
        // Halt takes priority over a coincident budget expiry.
        if (in_halt) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (budget_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
    load_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge in_Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      load_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      load_ready_q <= load_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      timeout_q    <= timeout_d;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge in_Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      csum_q    <= '0;
      csum_ok_q <= 1'b0;
    end else begin
      csum_q    <= csum_d;
      csum_ok_q <= csum_ok_d;
    end
  end

  assign out_csum_ok = csum_ok_q;
`endif

  assign out_load_ready     = load_ready_q;
  assign out_imem_wr_en     = wr_en_q;
  assign out_imem_wr_addr   = wr_addr_q;
  assign out_imem_wr_data   = wr_data_q;
  assign out_done_load_inst = (state_q == HOLD) || (state_q == RUN) || (state_q == DONE);
  assign out_core_rst_n     = (state_q == RUN) || (state_q == DONE);
  assign out_run_done       = (state_q == DONE);
  assign out_timeout        = timeout_q;
  assign out_error          = (state_q == ERROR);
  assign out_cycle_count    = run_count;

endmodule
